// File: rtl/mmu_sched_pkg.sv
// Shared types and constants for the tiled mmu scheduler.
package mmu_sched_pkg;

  localparam int TILE_CNT_W  = 8;
  localparam int MMU_MIN_GAP = 2;

  typedef logic [TILE_CNT_W-1:0] tile_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    GAP,
    WB,
    ADV,
    DONE
  } sched_state_t;

  // The mmu needs at least MMU_MIN_GAP idle cycles between enable windows.
  function automatic int gap_len(input int requested);
    return (requested < MMU_MIN_GAP) ? MMU_MIN_GAP : requested;
  endfunction

endpackage

// File: rtl/mmu_tile_idx_cnt.sv
// Nested tile index counters: level 0 = k (innermost), 1 = n, 2 = m (outermost).
module mmu_tile_idx_cnt
  import mmu_sched_pkg::*;
#(
  parameter int CNT_W = TILE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] k_m1,
  input  logic [CNT_W-1:0] n_m1,
  input  logic [CNT_W-1:0] m_m1,
  output logic [CNT_W-1:0] k_idx,
  output logic [CNT_W-1:0] n_idx,
  output logic [CNT_W-1:0] m_idx,
  output logic             last
);

  logic [CNT_W-1:0] lim [3];
  logic [CNT_W-1:0] idx [3];
  logic [2:0]       wrap;

  assign lim[0] = k_m1;
  assign lim[1] = n_m1;
  assign lim[2] = m_m1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lvl
      logic             lower_wrap;
      logic [CNT_W-1:0] cnt_reg;

      // A level steps only when every faster level is wrapping this cycle.
      if (gi == 0) begin : g_first
        assign lower_wrap = 1'b1;
      end else begin : g_upper
        assign lower_wrap = &wrap[gi-1:0];
      end

      assign wrap[gi] = (cnt_reg == lim[gi]);
      assign idx[gi]  = cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (advance && lower_wrap) begin
          cnt_reg <= wrap[gi] ? '0 : cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign k_idx = idx[0];
  assign n_idx = idx[1];
  assign m_idx = idx[2];
  assign last  = &wrap;

endmodule

// File: rtl/mmu_tile_sched.sv
// Tile scheduler sequencing load / mmu compute / writeback over an M x N x K tile grid.
// Optional watchdog on mmu_data_ready is enabled by defining MMU_SCHED_TIMEOUT_EN.
module mmu_tile_sched
  import mmu_sched_pkg::*;
#(
  parameter int CNT_W      = TILE_CNT_W,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_m_m1,
  input  logic [CNT_W-1:0] cfg_n_m1,
  input  logic [CNT_W-1:0] cfg_k_m1,
  output logic             busy,
  output logic             done,
  output logic             load_req,
  input  logic             load_ack,
  output logic [CNT_W-1:0] m_idx,
  output logic [CNT_W-1:0] n_idx,
  output logic [CNT_W-1:0] k_idx,
  output logic             accum_clear,
  output logic             mmu_enable,
  input  logic             mmu_data_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             err
);

  localparam int GAP_LEN = gap_len(GAP_CYCLES);
  localparam int GAP_W   = $clog2(GAP_LEN + 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  sched_state_t     state_reg, state_next;
  logic [CNT_W-1:0] m_lim_reg, n_lim_reg, k_lim_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             accum_clear_reg;
  logic             cnt_clear, cnt_advance, cnt_last;
  logic             k_last, gap_done, timeout_hit;

  mmu_tile_idx_cnt #(
    .CNT_W (CNT_W)
  ) u_idx_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .k_m1    (k_lim_reg),
    .n_m1    (n_lim_reg),
    .m_m1    (m_lim_reg),
    .k_idx   (k_idx),
    .n_idx   (n_idx),
    .m_idx   (m_idx),
    .last    (cnt_last)
  );

  assign k_last   = (k_idx == k_lim_reg);
  assign gap_done = (gap_cnt_reg == GAP_W'(GAP_LEN - 1));

`ifdef MMU_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;

  // First COMPUTE cycle sees 0, so the abort lands TIMEOUT+1 cycles after enable rises.
  assign timeout_hit = (state_reg == COMPUTE) && !mmu_data_ready
                       && (to_cnt_reg == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      to_cnt_reg <= (state_reg == COMPUTE) ? to_cnt_reg + TO_W'(1) : '0;
      err_reg    <= err_reg | timeout_hit;
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      m_lim_reg       <= '0;
      n_lim_reg       <= '0;
      k_lim_reg       <= '0;
      gap_cnt_reg     <= '0;
      accum_clear_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + GAP_W'(1) : '0;
      if (cnt_clear) begin
        m_lim_reg <= cfg_m_m1;
        n_lim_reg <= cfg_n_m1;
        k_lim_reg <= cfg_k_m1;
      end
      // Tracks the index update so it is already settled when LOAD begins.
      if (cnt_clear) begin
        accum_clear_reg <= 1'b1;
      end else if (cnt_advance) begin
        accum_clear_reg <= k_last;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    load_req    = 1'b0;
    mmu_enable  = 1'b0;
    wb_valid    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_clear  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        load_req = 1'b1;
        if (load_ack) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy       = 1'b1;
        mmu_enable = 1'b1;
        if (mmu_data_ready) begin
          state_next = GAP;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_done) state_next = k_last ? WB : ADV;
      end
      WB: begin
        busy     = 1'b1;
        wb_valid = 1'b1;
        if (wb_ready) state_next = ADV;
      end
      ADV: begin
        busy        = 1'b1;
        cnt_advance = 1'b1;
        state_next  = cnt_last ? DONE : LOAD;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accum_clear = accum_clear_reg;

`ifndef SYNTHESIS
  a_ready_only_in_compute: assert property (
    @(posedge clk) disable iff (!rst_n) mmu_data_ready |-> (state_reg == COMPUTE)
  );
`endif

endmodule

// File: tb/tb_mmu_tile_sched.sv
// Scoreboard bench for mmu_tile_sched: loader, mmu and writeback models plus a reference matrix product.
module tb_mmu_tile_sched;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_m_m1 = '0, cfg_n_m1 = '0, cfg_k_m1 = '0;
  logic          busy, done, load_req, accum_clear, mmu_enable, wb_valid, err;
  logic          load_ack = 1'b0, mmu_data_ready = 1'b0, wb_ready = 1'b0;
  logic [CW-1:0] m_idx, n_idx, k_idx;

  always #5 clk = ~clk;

  mmu_tile_sched #(
    .CNT_W      (CW),
    .GAP_CYCLES (2),
    .TIMEOUT    (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_m_m1       (cfg_m_m1),
    .cfg_n_m1       (cfg_n_m1),
    .cfg_k_m1       (cfg_k_m1),
    .busy           (busy),
    .done           (done),
    .load_req       (load_req),
    .load_ack       (load_ack),
    .m_idx          (m_idx),
    .n_idx          (n_idx),
    .k_idx          (k_idx),
    .accum_clear    (accum_clear),
    .mmu_enable     (mmu_enable),
    .mmu_data_ready (mmu_data_ready),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .err            (err)
  );

  typedef struct {
    int m;
    int n;
    int c;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      a_t[4][4];
  int      b_t[4][4];
  int      cur_prod = 0;
  int      mat_out = 0;
  int      checks = 0;
  int      errors = 0;
  int      launches = 0;
  int      wbs = 0;
  int      cyc = 0;
  int      last_hs_cyc = 0;
  int      ld_fix = -1;
  int      wb_fix = -1;
  bit      mmu_never = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Loader: acknowledges after 0..5 cycles (or a fixed delay) and captures the tile product.
  initial begin : loader
    int ld_wait;
    ld_wait = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) load_ack = 1'b0;
      else if (load_ack) load_ack = 1'b0;
      else if (load_req) begin
        if (ld_wait == 0) begin
          load_ack = 1'b1;
          cur_prod = a_t[m_idx][k_idx] * b_t[k_idx][n_idx];
        end else ld_wait--;
      end else ld_wait = (ld_fix < 0) ? int'($urandom_range(0, 5)) : ld_fix;
    end
  end

  // Mmu: result pulse 1..4 cycles after enable rises; accumulates unless accum_clear.
  initial begin : mmu_model
    int cnt, lat;
    cnt = 0;
    lat = 3;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mmu_data_ready = 1'b0;
        cnt = 0;
        mat_out = 0;
      end else if (mmu_data_ready) mmu_data_ready = 1'b0;
      else if (mmu_enable && !mmu_never) begin
        if (cnt == lat) begin
          mmu_data_ready = 1'b1;
          mat_out = (accum_clear ? 0 : mat_out) + cur_prod;
        end
        cnt++;
      end else begin
        cnt = 0;
        lat = $urandom_range(1, 4);
      end
    end
  end

  // Writeback sink: stray ready pulses while idle, delayed acceptance while valid.
  initial begin : wb_sink
    int wb_wait;
    wb_wait = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) wb_ready = 1'b0;
      else if (wb_valid) begin
        if (wb_wait == 0) wb_ready = 1'b1;
        else begin
          wb_ready = 1'b0;
          wb_wait--;
        end
      end else begin
        wb_ready = 1'($urandom_range(0, 1));
        wb_wait = (wb_fix < 0) ? int'($urandom_range(0, 7)) : wb_fix;
      end
    end
  end

  initial begin : monitor
    bit      prev_en, pend, seen_win;
    int      low_run, pm, pn;
    wb_exp_t e;
    prev_en = 0; pend = 0; seen_win = 0; low_run = 0; pm = 0; pn = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_en = 0; pend = 0; seen_win = 0; low_run = 0;
      end else begin
        if (load_req || mmu_enable) check("accum_clear_vs_k", accum_clear, k_idx == 0);
        if (mmu_enable && !prev_en) begin
          launches++;
          if (seen_win) check("gap_low_ge2", low_run >= 2, 1);
          seen_win = 1;
          low_run = 0;
        end else if (!mmu_enable) low_run++;
        if (pend) begin
          check("wb_valid_held", wb_valid, 1);
          check("wb_m_stable", m_idx, pm);
          check("wb_n_stable", n_idx, pn);
        end
        if (wb_valid && wb_ready) begin
          wbs++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_extra_tile: got tile (%0d,%0d) expected none", m_idx, n_idx);
          end else begin
            e = exp_q.pop_front();
            check("wb_m_idx", m_idx, e.m);
            check("wb_n_idx", n_idx, e.n);
            check("wb_tile_value", mat_out, e.c);
          end
        end
        if (done && !err) check("done_after_adv", cyc - last_hs_cyc, 2);
        pend = wb_valid && !wb_ready;
        pm = m_idx;
        pn = n_idx;
        prev_en = mmu_enable;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_load_req"}, load_req, 0);
    check({tag, "_mmu_enable"}, mmu_enable, 0);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_m_idx"}, m_idx, 0);
    check({tag, "_n_idx"}, n_idx, 0);
    check({tag, "_k_idx"}, k_idx, 0);
    check({tag, "_accum_clear"}, accum_clear, 1);
  endtask

  // Fill operand tables, push the reference C = A x B tiles in writeback order, pulse start.
  task automatic kick(input int mm, input int nn, input int kk);
    int c;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_t[i][j] = $urandom_range(0, 15);
        b_t[i][j] = $urandom_range(0, 15);
      end
    exp_q.delete();
    for (int m = 0; m <= mm; m++)
      for (int n = 0; n <= nn; n++) begin
        c = 0;
        for (int k = 0; k <= kk; k++) c += a_t[m][k] * b_t[k][n];
        exp_q.push_back('{m, n, c});
      end
    launches = 0;
    wbs = 0;
    @(posedge clk); #1;
    cfg_m_m1 = CW'(mm);
    cfg_n_m1 = CW'(nn);
    cfg_k_m1 = CW'(kk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_job(input int mm, input int nn, input int kk,
                         input int ldf, input int wbf, input bit poke);
    bit got;
    ld_fix = ldf;
    wb_fix = wbf;
    kick(mm, nn, kk);
    if (poke) begin
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1;
      cfg_m_m1 = 3;
      cfg_n_m1 = 3;
      cfg_k_m1 = 3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge clk); #1;
      if (done) got = 1;
    end
    check("done_seen", got, 1);
    if (got) begin
      check("busy_low_in_done", busy, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_one_cycle", done, 0);
      check("start_in_done_ignored", busy, 0);
      check("launch_count", launches, (mm + 1) * (nn + 1) * (kk + 1));
      check("wb_count", wbs, (mm + 1) * (nn + 1));
      check("queue_drained", exp_q.size(), 0);
    end
    exp_q.delete();
  endtask

  initial begin : main
    bit got;
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_job(0, 0, 0, 0, 0, 0);
    run_job(1, 1, 2, -1, -1, 1);
    run_job(1, 1, 2, 5, 7, 0);
    run_job(1, 1, 2, 0, 0, 0);
    run_job(2, 1, 1, -1, -1, 1);
    run_job(0, 2, 3, -1, -1, 0);

    // Reset during the third launch's COMPUTE.
    ld_fix = -1;
    wb_fix = -1;
    kick(1, 1, 2);
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk); #1;
      if (launches >= 3 && mmu_enable) got = 1;
    end
    check("third_launch_seen", got, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    run_job(1, 1, 2, -1, -1, 0);

    // Mmu never answers.
    mmu_never = 1'b1;
    kick(0, 0, 0);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (mmu_enable) got = 1;
    end
    check("never_enable_rose", got, 1);
`ifdef MMU_SCHED_TIMEOUT_EN
    n = 0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    check("to_done_seen", got, 1);
    check("to_done_latency_11_12", (n >= 11 && n <= 12), 1);
    check("to_err", err, 1);
    check("to_enable_low", mmu_enable, 0);
`else
    n = 0;
    repeat (1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("stuck_enable_high", mmu_enable, 1);
    check("stuck_busy", busy, 1);
    check("stuck_no_done", done, 0);
    check("stuck_err_zero", err, 0);
`endif
    rst_n = 1'b0;
    #1;
    check("final_reset_err", err, 0);
    mmu_never = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
